// File: rtl/fir_sample_feeder.sv
// Sample feeder for the direct-form FIR: buffers bursty valid/ready input and
// emits one strobed sample every RATE_DIV cycles. Optional: FEEDER_HOLD_LAST_EN.
module fir_sample_feeder #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int RATE_DIV = 4,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        sample_x,
  output logic                     sample_strobe,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [CNT_W-1:0]         underflow_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int DW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

  localparam logic [FW-1:0]    FULL_LVL = FW'(DEPTH);
  localparam logic [FW-1:0]    HALF_LVL = FW'(DEPTH / 2);
  localparam logic [DW-1:0]    DIV_LAST = DW'(RATE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [DW-1:0]     divider, divider_next;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic push, tick, pop, underflow, fifo_empty;

  assign in_ready   = reset_n && (fill_level != FULL_LVL) && !flush;
  assign push       = in_valid && in_ready;
  assign fifo_empty = (fill_level == '0);
  // A tick is suppressed by flush and by the cycle in which enable drops.
  assign tick       = (state == RUN) && enable && !flush && (divider == DIV_LAST);
  assign pop        = tick && !fifo_empty;
  assign underflow  = tick && fifo_empty;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_next   = state;
    divider_next = '0;
    if (flush) begin
      state_next = enable ? PRIME : IDLE;
    end else begin
      unique case (state)
        IDLE:  if (enable) state_next = PRIME;
        PRIME: begin
          if (!enable)                      state_next = IDLE;
          else if (fill_level >= HALF_LVL)  state_next = RUN;
        end
        RUN: begin
          if (!enable) state_next = IDLE;
          else         divider_next = (divider == DIV_LAST) ? '0 : divider + DW'(1);
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      divider <= '0;
    end else begin
      state   <= state_next;
      divider <= divider_next;
    end
  end

  // NOTE: storage array carries no reset; pointers and fill_level define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fill_level <= fill_level + FW'(1);
        2'b01:   fill_level <= fill_level - FW'(1);
        default: fill_level <= fill_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_x      <= '0;
      sample_strobe <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      sample_strobe <= 1'b0;
      if (flush) begin
        sample_x <= '0;
      end else if (pop) begin
        sample_x      <= mem[rd_ptr];
        sample_strobe <= 1'b1;
      end else if (underflow) begin
`ifdef FEEDER_HOLD_LAST_EN
        sample_x      <= sample_x;
`else
        sample_x      <= '0;
`endif
        sample_strobe <= 1'b1;
        if (underflow_cnt != CNT_MAX) underflow_cnt <= underflow_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Scoreboard bench for fir_sample_feeder: accepted pushes queue expected samples,
// a negedge monitor checks every strobe, level, ready and underflow count.
module tb_fir_sample_feeder;

  localparam int DATA_W   = 32;
  localparam int DEPTH    = 16;
  localparam int RATE_DIV = 4;
  localparam int CNT_W    = 4;
  localparam int FW       = $clog2(DEPTH) + 1;
  localparam int UF_MAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic              flush = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] sample_x;
  logic              sample_strobe;
  logic [FW-1:0]     fill_level;
  logic [CNT_W-1:0]  underflow_cnt;

  fir_sample_feeder #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .RATE_DIV(RATE_DIV), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sample_x(sample_x), .sample_strobe(sample_strobe),
    .fill_level(fill_level), .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                idx;   // monitor index at which the push was seen pending
  } entry_t;

  entry_t            exp_q[$];
  int                checks = 0;
  int                errors = 0;
  int                neg_idx = 0;
  int                strobe_count = 0;
  int                uf_model = 0;
  int                last_strobe_idx = -1;
  int                fill8_idx = 0;
  bit                mon_en = 1'b0;
  bit                period_chk = 1'b0;
  bit                lat_arm = 1'b0;
  bit                lat_pend = 1'b0;
  bit                prev_enable = 1'b0;
  bit                prev_flush = 1'b0;
  bit                src_done = 1'b0;
  logic [DATA_W-1:0] model_x = '0;
  logic              exp_ready;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic timeout(input string name, input int got, input int need);
    checks++;
    errors++;
    $display("FAIL %s timeout: got %0d needed %0d (t=%0t)", name, got, need, $time);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] v);
    int g = 0;
    in_data  = v;
    in_valid = 1'b1;
    while (!in_ready && g < 2000) begin cycle(); g++; end
    if (!in_ready) timeout("push_ready", g, 2000);
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic wait_fill(input int target, input int budget);
    int g = 0;
    while (int'(fill_level) != target && g < budget) begin cycle(); g++; end
    if (int'(fill_level) != target) timeout("wait_fill", int'(fill_level), target);
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int g = 0;
    while (strobe_count < target && g < budget) begin cycle(); g++; end
    if (strobe_count < target) timeout("wait_strobes", strobe_count, target);
  endtask

  // Reference: FIFO contents as a queue; a strobe delivers the oldest sample that
  // was already stored before the tick edge, otherwise it is an underflow.
  always @(negedge clk) begin
    if (mon_en) begin
      neg_idx++;
      if (prev_flush) begin
        exp_q.delete();
        model_x = '0;
        check("flush_strobe", 64'(sample_strobe), 64'd0);
      end else begin
        if (!prev_enable) check("idle_strobe", 64'(sample_strobe), 64'd0);
        if (sample_strobe === 1'b1) begin
          strobe_count++;
          if (exp_q.size() > 0 && exp_q[0].idx <= neg_idx - 2) begin
            model_x = exp_q[0].data;
            exp_q.delete(0);
          end else begin
`ifndef FEEDER_HOLD_LAST_EN
            model_x = '0;
`endif
            if (uf_model < UF_MAX) uf_model++;
          end
          if (lat_pend) begin
            check("first_strobe_latency", 64'(neg_idx - fill8_idx), 64'(RATE_DIV + 1));
            lat_pend = 1'b0;
          end
          if (period_chk && last_strobe_idx >= 0)
            check("strobe_period", 64'(neg_idx - last_strobe_idx), 64'(RATE_DIV));
          last_strobe_idx = neg_idx;
        end
      end
      check("sample_x", 64'(sample_x), 64'(model_x));
      check("fill_level", 64'(fill_level), 64'(exp_q.size()));
      check("underflow_cnt", 64'(underflow_cnt), 64'(uf_model));
      exp_ready = (exp_q.size() != DEPTH) && !flush;
      check("in_ready", 64'(in_ready), 64'(exp_ready));
      if (lat_arm && exp_q.size() == DEPTH / 2) begin
        fill8_idx = neg_idx;
        lat_arm   = 1'b0;
        lat_pend  = 1'b1;
      end
      if (in_valid && in_ready) exp_q.push_back('{data: in_data, idx: neg_idx});
      prev_enable = enable;
      prev_flush  = flush;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;

    // Reset release, then a mid-stream asynchronous reset.
    repeat (3) cycle();
    reset_n = 1'b1;
    #1;
    check("in_ready_after_reset", 64'(in_ready), 64'd1);
    mon_en = 1'b1;
    for (int v = 1; v <= 5; v++) push(DATA_W'(v));
    in_data  = DATA_W'(6);
    in_valid = 1'b1;
    #2;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_fill_level", 64'(fill_level), 64'd0);
    check("rst_sample_x", 64'(sample_x), 64'd0);
    check("rst_strobe", 64'(sample_strobe), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    exp_q.delete();
    model_x     = '0;
    uf_model    = 0;
    prev_enable = 1'b0;
    prev_flush  = 1'b0;
    cycle();
    reset_n = 1'b1;
    #1;
    check("in_ready_after_release", 64'(in_ready), 64'd1);
    mon_en = 1'b1;

    // Priming to half-full, first-strobe latency, then jittery streaming.
    enable          = 1'b1;
    last_strobe_idx = -1;
    period_chk      = 1'b1;
    lat_arm         = 1'b1;
    for (int v = 1; v <= 8; v++) push(DATA_W'(v));
    for (int v = 9; v <= 40; v++) begin
      repeat ($urandom_range(0, 3)) cycle();
      push(DATA_W'(v));
    end
    check("stream_no_underflow", 64'(underflow_cnt), 64'd0);
    check("first_strobe_seen", 64'(lat_pend), 64'd0);

    // Fill to DEPTH while disabled, then stream and drain into saturating underflow.
    period_chk = 1'b0;
    enable     = 1'b0;
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    fork
      begin
        for (int v = 1; v <= 20; v++) push(DATA_W'(v));
        src_done = 1'b1;
      end
    join_none
    wait_fill(DEPTH, 200);
    repeat (5) cycle();
    enable          = 1'b1;
    last_strobe_idx = -1;
    period_chk      = 1'b1;
    base            = strobe_count;
    wait_strobes(base + 20 + UF_MAX + 3, 600);
    check("underflow_saturated", 64'(underflow_cnt), 64'(UF_MAX));
    check("source_done", 64'(src_done), 64'd1);

    // Flush in RUN with a colliding push; feeder must re-prime from empty.
    period_chk = 1'b0;
    enable     = 1'b0;
    cycle();
    for (int v = 0; v < 10; v++) push(DATA_W'(32'h100 + v));
    enable = 1'b1;
    wait_fill(6, 300);
    flush    = 1'b1;
    in_data  = DATA_W'(32'hAA);
    in_valid = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    base     = strobe_count;
    repeat (20) cycle();
    check("prime_no_strobe", 64'(strobe_count), 64'(base));
    for (int v = 0; v < 8; v++) push(DATA_W'(32'h200 + v));
    wait_strobes(base + 8, 200);
    enable = 1'b0;
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
